// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle RV32I control unit.
// Contents: FSM state enum, RV32I opcode constants, datapath select encodings.
// Macro FSM_ILLEGAL_TRAP_EN adds the ERROR state for illegal opcodes.
package ctrl_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned INSTRET_W = 32;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
`ifdef FSM_ILLEGAL_TRAP_EN
        S_JAL,
        S_ERROR
`else
        S_JAL
`endif
    } state_t;

    // RV32I major opcodes
    localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;

    // ALU operand A select
    localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_OLDPC  = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;

    // ALU operand B select
    localparam logic [SEL_W-1:0] SRC_B_RS2    = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b10;

    // Result select
    localparam logic [SEL_W-1:0] RES_ALUOUT   = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA  = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES   = 2'b10;

    // ALU-op class handed to the ALU decoder
    localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB    = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// multicycle_ctrl_outdec: combinational state -> control-word decoder.
// Inputs : state_i (FSM state), mem_ready_i, zero_i
// Outputs: datapath selects, write enables, mem_req_o, pc_write_o
//          (illegal_o only with FSM_ILLEGAL_TRAP_EN)
module multicycle_ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t           state_i,
    input  logic             mem_ready_i,
    input  logic             zero_i,
    output logic             mem_req_o,
    output logic [SEL_W-1:0] alu_op_o,
    output logic [SEL_W-1:0] alu_src_a_o,
    output logic [SEL_W-1:0] alu_src_b_o,
    output logic [SEL_W-1:0] result_src_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic             mem_write_o,
`ifdef FSM_ILLEGAL_TRAP_EN
    output logic             pc_write_o,
    output logic             illegal_o
`else
    output logic             pc_write_o
`endif
);

    logic pc_update;
    logic branch;

    // Moore decode; only FETCH (ir/pc update) and BEQ (pc_write) see inputs
    always_comb begin
        mem_req_o    = 1'b0;
        alu_op_o     = ALUOP_ADD;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        result_src_o = RES_ALUOUT;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_write_o  = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
`ifdef FSM_ILLEGAL_TRAP_EN
        illegal_o    = 1'b0;
`endif
        case (state_i)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_a_o  = SRC_A_PC;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALURES;
                alu_op_o     = ALUOP_ADD;
                ir_write_o   = mem_ready_i;
                pc_update    = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o  = SRC_A_OLDPC;
                alu_src_b_o  = SRC_B_IMM;
                alu_op_o     = ALUOP_ADD;
            end
            S_MEMADR: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_IMM;
                alu_op_o     = ALUOP_ADD;
            end
            S_MEMREAD: begin
                mem_req_o    = 1'b1;
                adr_src_o    = 1'b1;
                result_src_o = RES_ALUOUT;
            end
            S_MEMWB: begin
                result_src_o = RES_MEMDATA;
                reg_write_o  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_o    = 1'b1;
                mem_write_o  = 1'b1;
                adr_src_o    = 1'b1;
                result_src_o = RES_ALUOUT;
            end
            S_EXECUTER: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_RS2;
                alu_op_o     = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_IMM;
                alu_op_o     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src_o = RES_ALUOUT;
                reg_write_o  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_RS2;
                alu_op_o     = ALUOP_SUB;
                result_src_o = RES_ALUOUT;
                branch       = 1'b1;
            end
            S_JAL: begin
                alu_src_a_o  = SRC_A_OLDPC;
                alu_src_b_o  = SRC_B_FOUR;
                alu_op_o     = ALUOP_ADD;
                result_src_o = RES_ALUOUT;
                pc_update    = 1'b1;
            end
`ifdef FSM_ILLEGAL_TRAP_EN
            S_ERROR: begin
                illegal_o    = 1'b1;
            end
`endif
            default: ;
        endcase
        pc_write_o = pc_update | (branch & zero_i);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Inputs : clk_i, rst_i (sync, active-high), opcode_i, zero_i, mem_ready_i
// Outputs: mem_req_o, alu_op_o, alu_src_a_o, alu_src_b_o, result_src_o,
//          adr_src_o, ir_write_o, reg_write_o, mem_write_o, pc_write_o,
//          instret_o (retired count), illegal_o (FSM_ILLEGAL_TRAP_EN only)
// Macro FSM_ILLEGAL_TRAP_EN: unknown opcodes trap into ERROR instead of
// retiring as a NOP.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [OPCODE_W-1:0]  opcode_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic [SEL_W-1:0]     alu_op_o,
    output logic [SEL_W-1:0]     alu_src_a_o,
    output logic [SEL_W-1:0]     alu_src_b_o,
    output logic [SEL_W-1:0]     result_src_o,
    output logic                 adr_src_o,
    output logic                 ir_write_o,
    output logic                 reg_write_o,
    output logic                 mem_write_o,
    output logic                 pc_write_o,
`ifdef FSM_ILLEGAL_TRAP_EN
    output logic [INSTRET_W-1:0] instret_o,
    output logic                 illegal_o
`else
    output logic [INSTRET_W-1:0] instret_o
`endif
);

    state_t               state_q;
    state_t               state_d;
    logic [INSTRET_W-1:0] instret_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retire counter: every entry into FETCH from another state retires one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= '0;
        end else if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret_o = instret_q;

    // Next-state logic; opcode only consulted in DECODE and MEMADR
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef FSM_ILLEGAL_TRAP_EN
                    default:      state_d = S_ERROR;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
`ifdef FSM_ILLEGAL_TRAP_EN
            S_ERROR:    state_d = S_ERROR;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_outdec u_outdec (
        .state_i      (state_q),
        .mem_ready_i  (mem_ready_i),
        .zero_i       (zero_i),
        .mem_req_o    (mem_req_o),
        .alu_op_o     (alu_op_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .result_src_o (result_src_o),
        .adr_src_o    (adr_src_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .mem_write_o  (mem_write_o),
`ifdef FSM_ILLEGAL_TRAP_EN
        .pc_write_o   (pc_write_o),
        .illegal_o    (illegal_o)
`else
        .pc_write_o   (pc_write_o)
`endif
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// The reference model walks a per-instruction schedule of phases and
// retires an instruction whenever the schedule runs out.
module tb_multicycle_ctrl;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1111111;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB,
                      P_MEMWRITE, P_EXR, P_EXI, P_ALUWB, P_BEQ, P_JAL,
                      P_ERROR} ph_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [6:0]  opcode_i = '0;
    logic        zero_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        mem_req_o, adr_src_o, ir_write_o, reg_write_o;
    logic        mem_write_o, pc_write_o;
    logic [1:0]  alu_op_o, alu_src_a_o, alu_src_b_o, result_src_o;
    logic [31:0] instret_o;
    logic        illegal_act;
`ifdef FSM_ILLEGAL_TRAP_EN
    logic        illegal_o;
    assign illegal_act = illegal_o;
`else
    assign illegal_act = 1'b0;
`endif

    multicycle_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .alu_op_o     (alu_op_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .result_src_o (result_src_o),
        .adr_src_o    (adr_src_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .mem_write_o  (mem_write_o),
        .pc_write_o   (pc_write_o),
`ifdef FSM_ILLEGAL_TRAP_EN
        .instret_o    (instret_o),
        .illegal_o    (illegal_o)
`else
        .instret_o    (instret_o)
`endif
    );

    always #5 clk = ~clk;

    logic [13:0] dut_word;
    assign dut_word = {mem_req_o, alu_op_o, alu_src_a_o, alu_src_b_o,
                       result_src_o, adr_src_o, ir_write_o, reg_write_o,
                       mem_write_o, pc_write_o};

    int          n_checks = 0;
    int          n_errors = 0;
    ph_t         cur = P_FETCH;
    ph_t         sched[$];
    logic [6:0]  cur_op = '0;
    logic [31:0] cnt = '0;
    bit          known = 1'b0;

`ifdef FSM_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Expected control word for a phase, built field by field
    function automatic logic [13:0] exp_word(ph_t ph, bit rdy, bit zr);
        logic       mreq = 0, adr = 0, ir = 0, rw = 0, mw = 0, pcw = 0;
        logic [1:0] op = 0, a = 0, b = 0, r = 0;
        case (ph)
            P_FETCH:    begin mreq = 1; b = 2; r = 2; ir = rdy; pcw = rdy; end
            P_DECODE:   begin a = 1; b = 1; end
            P_MEMADR:   begin a = 2; b = 1; end
            P_MEMREAD:  begin mreq = 1; adr = 1; end
            P_MEMWB:    begin r = 1; rw = 1; end
            P_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
            P_EXR:      begin a = 2; op = 2; end
            P_EXI:      begin a = 2; b = 1; op = 2; end
            P_ALUWB:    begin rw = 1; end
            P_BEQ:      begin a = 2; op = 1; pcw = zr; end
            P_JAL:      begin a = 1; b = 2; pcw = 1; end
            default:    ;
        endcase
        return {mreq, op, a, b, r, adr, ir, rw, mw, pcw};
    endfunction

    // Phases an instruction walks after FETCH
    task automatic build_sched(input logic [6:0] op);
        sched.delete();
        sched.push_back(P_DECODE);
        case (op)
            T_LW:  begin sched.push_back(P_MEMADR); sched.push_back(P_MEMREAD);
                         sched.push_back(P_MEMWB); end
            T_SW:  begin sched.push_back(P_MEMADR); sched.push_back(P_MEMWRITE); end
            T_R:   begin sched.push_back(P_EXR); sched.push_back(P_ALUWB); end
            T_I:   begin sched.push_back(P_EXI); sched.push_back(P_ALUWB); end
            T_BEQ: sched.push_back(P_BEQ);
            T_JAL: begin sched.push_back(P_JAL); sched.push_back(P_ALUWB); end
            default: if (TRAP) sched.push_back(P_ERROR);
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare, then advance the model
    task automatic cycle(input bit rst, input bit rdy, input bit zr,
                         input logic [6:0] op_next);
        @(negedge clk);
        rst_i       = rst;
        mem_ready_i = rdy;
        zero_i      = zr;
        opcode_i    = (cur == P_FETCH) ? 7'($urandom) : cur_op;
        #1;
        if (known) begin
            chk($sformatf("ctrl_word ph=%0d", cur), 32'(dut_word),
                32'(exp_word(cur, rdy, zr)));
            chk("instret", instret_o, cnt);
            chk("illegal", 32'(illegal_act), 32'(cur == P_ERROR));
        end
        if (rst) begin
            cur = P_FETCH; sched.delete(); cnt = '0; known = 1'b1;
        end else if ((cur == P_FETCH || cur == P_MEMREAD || cur == P_MEMWRITE) && !rdy) begin
            cur = cur;
        end else if (cur == P_FETCH) begin
            cur_op = op_next;
            build_sched(op_next);
            cur = sched.pop_front();
        end else if (cur == P_ERROR) begin
            cur = P_ERROR;
        end else if (sched.size() == 0) begin
            cnt = cnt + 32'd1;
            cur = P_FETCH;
        end else begin
            cur = sched.pop_front();
        end
    endtask

    task automatic run_instr(input logic [6:0] op);
        int guard = 0;
        cycle(0, 1, 0, op);
        while (cur != P_FETCH && guard < 20) begin
            cycle(0, 1, 0, op);
            guard++;
        end
    endtask

    logic [6:0] legal_ops [6] = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};

    initial begin
        int mw_cycles;
        // Reset, then reset-state control word
        cycle(1, 0, 0, T_R);
        cycle(1, 0, 0, T_R);
        @(posedge clk); #1;
        chk("reset_word", 32'(dut_word), 32'h2140);
        chk("reset_instret", instret_o, 32'd0);

        // R-type retires after 4 cycles
        run_instr(T_R);
        @(posedge clk); #1;
        chk("instret_after_r", instret_o, 32'd1);

        // lw with 3 wait cycles in MEMREAD
        cycle(0, 1, 0, T_LW); cycle(0, 1, 0, T_LW); cycle(0, 1, 0, T_LW);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, T_LW);
        cycle(0, 1, 0, T_LW);
        cycle(0, 1, 0, T_LW);
        chk("lw_memwb_result", 32'(result_src_o), 32'd1);

        // beq taken then not taken
        cycle(0, 1, 1, T_BEQ); cycle(0, 1, 1, T_BEQ); cycle(0, 1, 1, T_BEQ);
        chk("beq_taken_pcw", 32'(pc_write_o), 32'd1);
        cycle(0, 1, 0, T_BEQ); cycle(0, 1, 0, T_BEQ); cycle(0, 1, 0, T_BEQ);
        chk("beq_not_taken_pcw", 32'(pc_write_o), 32'd0);
        @(posedge clk); #1;
        chk("instret_after_beq", instret_o, 32'd4);

        // jal
        cycle(0, 1, 0, T_JAL); cycle(0, 1, 0, T_JAL); cycle(0, 1, 0, T_JAL);
        chk("jal_sel", 32'({pc_write_o, alu_src_a_o, alu_src_b_o}), 32'b1_01_10);
        cycle(0, 1, 0, T_JAL);

        // sw with 2 waits: mem_write high for exactly 3 cycles
        mw_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, (i < 3 || i == 5), 0, T_SW);
            mw_cycles += int'(mem_write_o);
        end
        chk("sw_mem_write_cycles", 32'(mw_cycles), 32'd3);
        @(posedge clk); #1;
        chk("instret_after_sw", instret_o, 32'd6);

        // Wrap: preload all-ones while stalled in FETCH
        cycle(0, 0, 0, T_R);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        cnt = 32'hFFFF_FFFF;
        run_instr(T_I);
        @(posedge clk); #1;
        chk("instret_wrap", instret_o, 32'd0);
        run_instr(T_R);

        // Reset pulsed in MEMREAD
        cycle(0, 1, 0, T_LW); cycle(0, 1, 0, T_LW); cycle(0, 1, 0, T_LW);
        cycle(1, 0, 0, T_LW);
        @(posedge clk); #1;
        chk("rst_memread_word", 32'(dut_word), 32'h2140);
        chk("rst_memread_instret", instret_o, 32'd0);

        // Illegal opcode
        cycle(0, 1, 0, T_BAD); cycle(0, 1, 0, T_BAD);
        if (TRAP) begin
            for (int i = 0; i < 3; i++) cycle(0, 1, 0, T_R);
            chk("illegal_hold", 32'(illegal_act), 32'd1);
            chk("illegal_instret", instret_o, 32'd0);
            cycle(1, 0, 0, T_R);
        end else begin
            @(posedge clk); #1;
            chk("illegal_nop_instret", instret_o, 32'd1);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit         rst, rdy, zr;
            logic [6:0] op;
            int         r;
            rst = ($urandom_range(99) < 2) || (cur == P_ERROR && $urandom_range(3) == 0);
            rdy = ($urandom_range(9) < 7);
            zr  = 1'($urandom);
            r   = int'($urandom_range(15));
            if (r < 14)       op = legal_ops[r % 6];
            else if (r == 14) op = T_BAD;
            else              op = 7'($urandom);
            cycle(rst, rdy, zr, op);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle RV32I core, directly upstream of the ALU decoder. A Moore state machine walks each instruction through fetch, decode, execute, memory and writeback. Per state it drives the datapath mux selects, the write enables and the 2-bit ALU-op class that the ALU decoder turns into an ALU operation. Memory accesses use a ready handshake, and the block counts retired instructions.

## Interface
- No parameters.
- clk_i  in  1  core clock; all state changes on the rising edge
- rst_i  in  1  synchronous reset, active-high
- opcode_i  in  7  instruction register bits [6:0]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current access this cycle
- mem_req_o  out  1  memory access requested
- alu_op_o  out  2  to the ALU decoder: 00 add, 01 sub, 10 funct-decoded
- alu_src_a_o  out  2  ALU operand A select: 00 PC, 01 OldPC, 10 rs1 data
- alu_src_b_o  out  2  ALU operand B select: 00 rs2 data, 01 immediate, 10 constant 4
- result_src_o  out  2  result select: 00 ALUOut, 01 memory data, 10 ALUResult
- adr_src_o  out  1  memory address select: 0 PC, 1 Result
- ir_write_o, reg_write_o, mem_write_o  out  1 each  write enables (instruction register, register file, memory)
- pc_write_o  out  1  pc_update OR (branch AND zero_i); combinational
- instret_o  out  32  count of retired instructions
- illegal_o  out  1  illegal opcode flag (only with FSM_ILLEGAL_TRAP_EN)

## Operation
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Outputs are decoded from the state only; pc_write_o additionally uses zero_i. Any output not listed for a state is 0.
- States and their outputs:
  - FETCH: mem_req=1, a=00, b=10, result=10, op=00. When mem_ready_i=1, also ir_write=1 and pc_update=1.
  - DECODE: a=01, b=01, op=00 (computes the branch target).
  - MEMADR: a=10, b=01, op=00.
  - MEMREAD: mem_req=1, adr_src=1, result=00.
  - MEMWB: result=01, reg_write=1.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result=00.
  - EXECUTER: a=10, b=00, op=10.
  - EXECUTEI: a=10, b=01, op=10.
  - ALUWB: result=00, reg_write=1.
  - BEQ: a=10, b=00, op=01, result=00, branch=1.
  - JAL: a=01, b=10, op=00, result=00, pc_update=1.
- Transitions:
  - FETCH→DECODE when mem_ready_i=1, otherwise stay.
  - DECODE on opcode: lw/sw→MEMADR; R→EXECUTER; I→EXECUTEI; beq→BEQ; jal→JAL.
  - MEMADR→MEMREAD for lw, →MEMWRITE for sw.
  - MEMREAD→MEMWB when mem_ready_i=1, otherwise stay.
  - MEMWRITE→FETCH when mem_ready_i=1, otherwise stay.
  - EXECUTER, EXECUTEI, JAL→ALUWB.
  - MEMWB, ALUWB, BEQ→FETCH.
- instret_o increments by 1 on every transition into FETCH, except from reset. It wraps from 0xFFFFFFFF to 0.
- Opcode is decoded only in DECODE and MEMADR. The instruction register is stable there, so opcode_i is don't-care in every other state.

## Timing
- Reset: state=FETCH and instret_o=0. Outputs then hold the FETCH decode: mem_req=1, b=10, result=10, all others 0; ir_write and pc_update are 0 until mem_ready_i rises.
- rst_i asserted in any state, including a pending memory wait, returns to FETCH on the next edge. Any in-flight access is abandoned and the count is not incremented.
- Cycles with mem_ready_i held at 1:
  - lw: 5
  - sw: 4
  - R-type / I-ALU: 4
  - jal: 4
  - beq: 3
- Each cycle mem_ready_i is low in FETCH, MEMREAD or MEMWRITE adds one cycle. mem_write_o stays high for the entire MEMWRITE wait.
- pc_write_o in BEQ follows zero_i in the same cycle.

## Configuration
- FSM_ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE goes to state ERROR.
  - ERROR drives all outputs 0 except illegal_o=1 and holds until reset.
  - instret_o does not count the illegal instruction.
- FSM_ILLEGAL_TRAP_EN undefined: an unknown opcode in DECODE returns to FETCH as a NOP and is counted.
  - The ERROR state and the illegal_o port are absent.

## Structure
- Package ctrl_pkg holds:
  - the state enum type;
  - the opcode localparams;
  - the localparams for the alu_src_a, alu_src_b, result_src and alu_op encodings.
- The state register, next-state logic and instret counter live in multicycle_ctrl.
- Sub-module multicycle_ctrl_outdec is the purely combinational state→control-word decoder.

## Test plan
- Reset held for 2 cycles, then mem_ready_i=1 and opcode 0110011: FETCH, DECODE, EXECUTER (alu_op_o=10), ALUWB (reg_write_o=1), FETCH; instret_o=1.
- lw with mem_ready_i low for 3 cycles in MEMREAD: MEMREAD held 4 cycles with mem_req_o=1 and adr_src_o=1, then MEMWB with result_src_o=01.
- beq with zero_i=1: pc_write_o=1 in BEQ. Same instruction with zero_i=0: pc_write_o=0. Both return to FETCH after 3 cycles.
- jal: JAL with pc_write_o=1, a=01, b=10, then ALUWB; sw: mem_write_o=1 for exactly the MEMWRITE cycles.
- Preload instret to 0xFFFFFFFF via 2^32-free force, retire one instruction: instret_o=0. rst_i pulsed in MEMREAD: FETCH next cycle and instret_o=0.
- Opcode 1111111: with the macro, ERROR and illegal_o=1 until reset. Without it, FETCH next and instret_o incremented.
